// File: rtl/writeback_queue_pkg.sv
// Shared register-file types for the writeback path: widths and the queued
// write entry.
package riscv_pkg;

  localparam int REGISTER_WIDTH   = 64;
  localparam int REGISTERNO_WIDTH = 5;

  typedef struct packed {
    logic [REGISTERNO_WIDTH-1:0] regno;
    logic [REGISTER_WIDTH-1:0]   value;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Bundle of the writeback queue's producer, register-file write and hazard
// query signals.
interface writeback_queue_if;
  import riscv_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic [REGISTERNO_WIDTH-1:0] in_rd_regno;
  logic [REGISTER_WIDTH-1:0]   in_rd_value;
  logic                        in_hold;
  logic                        out_wr_enable;
  logic [REGISTERNO_WIDTH-1:0] out_rd_regno;
  logic [REGISTER_WIDTH-1:0]   out_rd_value;
  logic [REGISTERNO_WIDTH-1:0] in_rs1_regno;
  logic [REGISTERNO_WIDTH-1:0] in_rs2_regno;
  logic                        out_rs1_pending;
  logic                        out_rs2_pending;
  logic                        out_drained;

  modport master (
    output in_valid, in_rd_regno, in_rd_value, in_hold, in_rs1_regno, in_rs2_regno,
    input  in_ready, out_wr_enable, out_rd_regno, out_rd_value,
           out_rs1_pending, out_rs2_pending, out_drained
  );

  modport slave (
    input  in_valid, in_rd_regno, in_rd_value, in_hold, in_rs1_regno, in_rs2_regno,
    output in_ready, out_wr_enable, out_rd_regno, out_rd_value,
           out_rs1_pending, out_rs2_pending, out_drained
  );

endinterface

// File: rtl/writeback_queue_wb_entry_fifo.sv
// In-order entry storage with head/tail pointers, occupancy count and a
// per-slot valid vector so the top can compare every queued regno.
module wb_entry_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head_entry,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      valid,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  wb_entry_t [DEPTH-1:0] mem;
  logic                  do_push;
  logic                  do_pop;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign head_entry = mem[head];
  assign entries    = mem;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
      if (do_pop)  valid[head] <= 1'b0;
      if (do_push) valid[tail] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_entry;
  end

endmodule

// File: rtl/writeback_queue.sv
// Buffers completed results and drains one per cycle onto the register-file
// write port, reporting pending writes for two decode source registers.
module writeback_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  writeback_queue_if.slave bus
);

  wb_entry_t             push_entry;
  wb_entry_t             head_entry;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  wr_enable;
  logic [REGISTERNO_WIDTH-1:0] rd_regno;
  logic [REGISTER_WIDTH-1:0]   rd_value;
  logic                  rs1_hit;
  logic                  rs2_hit;

  // Writes to x0 complete the handshake but are never stored.
  assign push             = bus.in_valid & ~full & (bus.in_rd_regno != '0);
  assign pop              = ~empty & ~bus.in_hold;
  assign push_entry.regno = bus.in_rd_regno;
  assign push_entry.value = bus.in_rd_value;

  wb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .entries    (entries),
    .valid      (valid),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_enable <= 1'b0;
      rd_regno  <= '0;
      rd_value  <= '0;
    end else begin
      wr_enable <= pop;
      if (pop) begin
        rd_regno <= head_entry.regno;
        rd_value <= head_entry.value;
      end
    end
  end

  // A source is pending while a write to it is queued or on the write port.
  always_comb begin
    rs1_hit = wr_enable && (rd_regno == bus.in_rs1_regno);
    rs2_hit = wr_enable && (rd_regno == bus.in_rs2_regno);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].regno == bus.in_rs1_regno)) rs1_hit = 1'b1;
      if (valid[i] && (entries[i].regno == bus.in_rs2_regno)) rs2_hit = 1'b1;
    end
  end

  assign bus.in_ready        = ~full;
  assign bus.out_wr_enable   = wr_enable;
  assign bus.out_rd_regno    = rd_regno;
  assign bus.out_rd_value    = rd_value;
  assign bus.out_rs1_pending = (bus.in_rs1_regno != '0) & rs1_hit;
  assign bus.out_rs2_pending = (bus.in_rs2_regno != '0) & rs2_hit;
  assign bus.out_drained     = empty & ~wr_enable;

endmodule
